up_down_counter_param: RTL

- Parametrised successor to the team's 8-bit free-running up/down counter.
- Adds:
  - configurable width and count bounds;
  - wrap or saturate mode;
  - count enable, synchronous clear and parallel load;
  - boundary flags and event pulses.
- Used as a general event/position counter in datapath and control blocks.
- All state is registered on `clk`; flags are for downstream control logic.

---
 rtl/udc_pkg.sv | 28 ++
 rtl/udc_prescaler.sv | 48 ++++
 rtl/up_down_counter_param.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/udc_pkg.sv
// -----------------------------------------------------------------------------
// udc_pkg
// Shared definitions for the parametrised up/down counter.
//   UDC_MODE_WRAP / UDC_MODE_SAT : values for the counter's SATURATE parameter
//   udc_clamp()                  : forces a value into [min_v, max_v]; used to
//                                  range-limit parallel loads
// -----------------------------------------------------------------------------
package udc_pkg;

   localparam int unsigned UDC_MODE_WRAP = 0;
   localparam int unsigned UDC_MODE_SAT  = 1;

   // 32-bit wide so a single function serves every counter width; callers
   // cast the result back to their own width.
   function automatic logic [31:0] udc_clamp(input logic [31:0] value,
                                             input logic [31:0] min_v,
                                             input logic [31:0] max_v);
      logic [31:0] res;
      res = value;
      if (value > max_v) begin
         res = max_v;
      end else if (value < min_v) begin
         res = min_v;
      end
      return res;
   endfunction

endpackage

// File: rtl/udc_prescaler.sv
// -----------------------------------------------------------------------------
// udc_prescaler
// Enable qualifier: counts en cycles modulo PRESCALE and raises step_en on
// the en cycle that completes a group of PRESCALE, so the counter steps once
// per PRESCALE enabled cycles. PRESCALE=1 makes step_en equal to en.
// Only instantiated when UDC_PRESCALE_EN is defined.
// Ports:
//   clk       input  clock, rising edge
//   rst_n     input  asynchronous active-low reset, tick counter -> 0
//   en        input  enable to be qualified
//   sync_clr  input  synchronous restart of the tick counter (clear/load)
//   step_en   output qualified enable, valid in the same cycle as en
// -----------------------------------------------------------------------------
module udc_prescaler
   import udc_pkg::*;
#(
   parameter int unsigned PRESCALE = 4
)(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic sync_clr,
   output logic step_en
);

   localparam int unsigned TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [TW-1:0] LAST = TW'(PRESCALE - 1);

   logic [TW-1:0] tick;

   // sync_clr wins over en so a load/clear cycle never counts as a tick.
   assign step_en = en && !sync_clr && (tick == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick <= '0;
      end else if (sync_clr) begin
         tick <= '0;
      end else if (en) begin
         if (tick == LAST) begin
            tick <= '0;
         end else begin
            tick <= tick + 1'b1;
         end
      end
   end

endmodule

// File: rtl/up_down_counter_param.sv
// -----------------------------------------------------------------------------
// up_down_counter_param
// Bounded up/down counter with wrap or saturate behaviour, synchronous clear,
// clamped parallel load, boundary flags and wrap/sat event pulses.
// Optional macro UDC_PRESCALE_EN: qualifies en through udc_prescaler so only
// every PRESCALE-th enabled cycle takes a step.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   en, up_down          step enable, direction (1 = up)
//   clear                synchronous clear to RESET_VAL (highest priority)
//   load, load_val       synchronous load, value clamped to the bounds
//   count                registered count, always in [MIN_VAL, MAX_VAL]
//   at_max, at_min       decode of count against the bounds
//   wrap, sat            one-cycle registered event pulses
// Interface timing: there is no handshake. Inputs are sampled on every rising
// edge; count, wrap and sat are valid every cycle after reset and reflect the
// inputs sampled on the previous edge.
// -----------------------------------------------------------------------------
module up_down_counter_param
   import udc_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MIN_VAL   = 0,
   parameter int unsigned MAX_VAL   = (32'd1 << WIDTH) - 32'd1,
   parameter int unsigned RESET_VAL = MIN_VAL,
   parameter int unsigned SATURATE  = UDC_MODE_WRAP,
   parameter int unsigned PRESCALE  = 4
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_down,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             at_max,
   output logic             at_min,
   output logic             wrap,
   output logic             sat
);

   // Parameter sanity; WIDTH is capped at 31 so the default MAX_VAL fits.
   if (WIDTH < 2 || WIDTH > 31) begin : g_bad_width
      $error("up_down_counter_param: WIDTH must be in [2,31]");
   end
   if (MAX_VAL <= MIN_VAL) begin : g_bad_bounds
      $error("up_down_counter_param: MAX_VAL must exceed MIN_VAL");
   end
   if (MAX_VAL > ((32'd1 << WIDTH) - 32'd1)) begin : g_bad_max
      $error("up_down_counter_param: MAX_VAL does not fit in WIDTH bits");
   end
   if (RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL) begin : g_bad_reset
      $error("up_down_counter_param: RESET_VAL outside [MIN_VAL, MAX_VAL]");
   end
   if (PRESCALE < 1) begin : g_bad_prescale
      $error("up_down_counter_param: PRESCALE must be at least 1");
   end

   localparam logic [WIDTH-1:0] MIN_C   = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);
   localparam bit               SAT_MODE = (SATURATE == UDC_MODE_SAT);

   logic             step;
   logic [WIDTH:0]   inc_val;
   logic [WIDTH:0]   dec_val;
   logic             inc_over;
   logic             dec_under;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] count_nxt;
   logic             wrap_nxt;
   logic             sat_nxt;

`ifdef UDC_PRESCALE_EN
   udc_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .sync_clr (clear | load),
      .step_en  (step)
   );
`else
   assign step = en;
`endif

   // One extra bit so +1 / -1 at the encoding limits cannot alias back into
   // range; the signed compare catches 0 - 1 underflow.
   assign inc_val   = {1'b0, count} + 1'b1;
   assign dec_val   = {1'b0, count} - 1'b1;
   assign inc_over  = inc_val > {1'b0, MAX_C};
   assign dec_under = $signed(dec_val) < $signed({1'b0, MIN_C});

   assign load_clamped = WIDTH'(udc_clamp(32'(load_val), MIN_VAL, MAX_VAL));

   always_comb begin
      count_nxt = count;
      wrap_nxt  = 1'b0;
      sat_nxt   = 1'b0;
      if (clear) begin
         count_nxt = RESET_C;
      end else if (load) begin
         count_nxt = load_clamped;
      end else if (step) begin
         if (up_down) begin
            if (!inc_over) begin
               count_nxt = inc_val[WIDTH-1:0];
            end else if (SAT_MODE) begin
               sat_nxt = 1'b1;
            end else begin
               count_nxt = MIN_C;
               wrap_nxt  = 1'b1;
            end
         end else begin
            if (!dec_under) begin
               count_nxt = dec_val[WIDTH-1:0];
            end else if (SAT_MODE) begin
               sat_nxt = 1'b1;
            end else begin
               count_nxt = MAX_C;
               wrap_nxt  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= RESET_C;
         wrap  <= 1'b0;
         sat   <= 1'b0;
      end else begin
         count <= count_nxt;
         wrap  <= wrap_nxt;
         sat   <= sat_nxt;
      end
   end

   assign at_max = (count == MAX_C);
   assign at_min = (count == MIN_C);

endmodule
